// File: rtl/sprite_compositor.sv
// Pipelined sprite-layer compositor: per-layer hit/ROM addressing, ROM latency alignment, priority + colour key.
// Optional per-frame collision mask, built only when SPRITE_COMP_COLLIDE_EN is defined.

module sprite_lane #(
  parameter int COORD_W  = 11,
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int ADDR_W   = 10
) (
  input  logic [COORD_W-1:0] cx_i,
  input  logic [COORD_W-1:0] cy_i,
  input  logic [COORD_W-1:0] lx_i,
  input  logic [COORD_W-1:0] ly_i,
  input  logic               en_i,
  output logic               hit_o,
  output logic [ADDR_W-1:0]  addr_o
);
  logic [COORD_W:0]   x_end, y_end;
  logic [COORD_W-1:0] dx, dy;

  // Upper bounds carry one extra bit so sprites at the coordinate edge never wrap.
  always_comb begin
    x_end  = {1'b0, lx_i} + (COORD_W+1)'(SPRITE_W);
    y_end  = {1'b0, ly_i} + (COORD_W+1)'(SPRITE_H);
    dx     = cx_i - lx_i;
    dy     = cy_i - ly_i;
    hit_o  = en_i && (cx_i >= lx_i) && ({1'b0, cx_i} < x_end)
                  && (cy_i >= ly_i) && ({1'b0, cy_i} < y_end);
    addr_o = '0;
    if (hit_o) addr_o = ADDR_W'(dx) + ADDR_W'(dy * SPRITE_W);
  end
endmodule

module sprite_compositor #(
  parameter int          NUM_LAYERS  = 4,
  parameter int          COORD_W     = 11,
  parameter int          SPRITE_W    = 32,
  parameter int          SPRITE_H    = 32,
  parameter int          ROM_LAT     = 1,
  parameter logic [11:0] TRANSPARENT = 12'h000,
  localparam int         ADDR_W      = $clog2(SPRITE_W*SPRITE_H),
  localparam int         LYR_W       = $clog2(NUM_LAYERS+1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pix_valid_i,
  input  logic                           frame_start_i,
  input  logic [COORD_W-1:0]             curr_x_i,
  input  logic [COORD_W-1:0]             curr_y_i,
  input  logic [NUM_LAYERS*COORD_W-1:0]  layer_x_i,
  input  logic [NUM_LAYERS*COORD_W-1:0]  layer_y_i,
  input  logic [NUM_LAYERS-1:0]          layer_en_i,
  input  logic [11:0]                    bg_color_i,
  output logic [NUM_LAYERS*ADDR_W-1:0]   rom_addr_o,
  input  logic [NUM_LAYERS*12-1:0]       rom_data_i,
  output logic                           out_valid_o,
  output logic [11:0]                    out_color_o,
  output logic [LYR_W-1:0]               out_layer_o,
  output logic [NUM_LAYERS-1:0]          collide_frame_o
);
  logic [NUM_LAYERS-1:0]              hit_c;
  logic [NUM_LAYERS-1:0][ADDR_W-1:0]  addr_c;
  logic [NUM_LAYERS-1:0][ADDR_W-1:0]  rom_addr_q;

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_lane
    sprite_lane #(
      .COORD_W (COORD_W), .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .ADDR_W(ADDR_W)
    ) u_lane (
      .cx_i  (curr_x_i),
      .cy_i  (curr_y_i),
      .lx_i  (layer_x_i[k*COORD_W +: COORD_W]),
      .ly_i  (layer_y_i[k*COORD_W +: COORD_W]),
      .en_i  (layer_en_i[k]),
      .hit_o (hit_c[k]),
      .addr_o(addr_c[k])
    );
  end

  // Index 0 is the stage-A register; index ROM_LAT lines up with rom_data_i.
  logic [ROM_LAT:0]                  vld_pipe;
  logic [ROM_LAT:0][NUM_LAYERS-1:0]  hit_pipe;
  logic [ROM_LAT:0][11:0]            bg_pipe;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe   <= '0;
      hit_pipe   <= '0;
      bg_pipe    <= '0;
      rom_addr_q <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[ROM_LAT-1:0], pix_valid_i};
      hit_pipe   <= {hit_pipe[ROM_LAT-1:0], hit_c};
      bg_pipe    <= {bg_pipe[ROM_LAT-1:0], bg_color_i};
      rom_addr_q <= addr_c;
    end
  end

  assign rom_addr_o = rom_addr_q;

  logic [NUM_LAYERS-1:0] opaque;
  logic [11:0]           color_d;
  logic [LYR_W-1:0]      layer_d;

  // Descending scan so the lowest opaque index is the final assignment.
  always_comb begin
    color_d = bg_pipe[ROM_LAT];
    layer_d = LYR_W'(NUM_LAYERS);
    for (int k = 0; k < NUM_LAYERS; k++)
      opaque[k] = hit_pipe[ROM_LAT][k] && (rom_data_i[k*12 +: 12] != TRANSPARENT);
    for (int k = NUM_LAYERS-1; k >= 0; k--) begin
      if (opaque[k]) begin
        color_d = rom_data_i[k*12 +: 12];
        layer_d = LYR_W'(k);
      end
    end
    if (!vld_pipe[ROM_LAT]) begin
      color_d = '0;
      layer_d = LYR_W'(NUM_LAYERS);
    end
  end

  logic             out_valid_q;
  logic [11:0]      out_color_q;
  logic [LYR_W-1:0] out_layer_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_color_q <= '0;
      out_layer_q <= LYR_W'(NUM_LAYERS);
    end else begin
      out_valid_q <= vld_pipe[ROM_LAT];
      out_color_q <= color_d;
      out_layer_q <= layer_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_color_o = out_color_q;
  assign out_layer_o = out_layer_q;

`ifdef SPRITE_COMP_COLLIDE_EN
  logic [NUM_LAYERS-1:0] acc_q, collide_q, contrib;

  // Only a pixel with two or more opaque layers marks a collision.
  assign contrib = (vld_pipe[ROM_LAT] && ((opaque & (opaque - 1'b1)) != '0)) ? opaque : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q     <= '0;
      collide_q <= '0;
    end else if (frame_start_i) begin
      collide_q <= acc_q | contrib;
      acc_q     <= '0;
    end else begin
      acc_q     <= acc_q | contrib;
    end
  end

  assign collide_frame_o = collide_q;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start_i;
  assign collide_frame_o    = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: reference model computes hits, priority and collisions from plain arithmetic.
module tb_sprite_compositor;
  localparam int NL = 4, CW = 11, AW = 10, LW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              pix_valid_i = 1'b0, frame_start_i = 1'b0;
  logic [CW-1:0]     curr_x_i = '0, curr_y_i = '0;
  logic [NL*CW-1:0]  layer_x_i = '0, layer_y_i = '0;
  logic [NL-1:0]     layer_en_i = '0;
  logic [11:0]       bg_color_i = '0;
  logic [NL*AW-1:0]  rom_addr_o;
  logic [NL*12-1:0]  rom_data_i;
  logic              out_valid_o;
  logic [11:0]       out_color_o;
  logic [LW-1:0]     out_layer_o;
  logic [NL-1:0]     collide_frame_o;

  sprite_compositor dut (
    .clk(clk), .rst(rst), .pix_valid_i(pix_valid_i), .frame_start_i(frame_start_i),
    .curr_x_i(curr_x_i), .curr_y_i(curr_y_i), .layer_x_i(layer_x_i), .layer_y_i(layer_y_i),
    .layer_en_i(layer_en_i), .bg_color_i(bg_color_i), .rom_addr_o(rom_addr_o),
    .rom_data_i(rom_data_i), .out_valid_o(out_valid_o), .out_color_o(out_color_o),
    .out_layer_o(out_layer_o), .collide_frame_o(collide_frame_o)
  );

  always #5 clk = ~clk;

  // Sprite ROMs with one cycle of read latency.
  logic [11:0] mem [NL][1024];
  always @(posedge clk)
    for (int k = 0; k < NL; k++) rom_data_i[k*12 +: 12] <= mem[k][rom_addr_o[k*AW +: AW]];

  typedef struct { logic [11:0] color; int layer; } out_t;
  typedef struct { logic [NL*AW-1:0] addr; logic [NL-1:0] coll; } cyc_t;
  out_t out_q[$];
  cyc_t cyc_q[$];

  int vectors = 0, miscompares = 0;
  logic [NL-1:0] acc_m = '0, coll_m = '0;
  logic [NL-1:0] hist [3] = '{default: '0};

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compute expectations for the inputs currently driven, then advance one clock.
  task automatic cycle();
    cyc_t c;
    out_t o;
    logic [NL-1:0] op, contrib;
    int win, waddr;
    c.addr = '0; op = '0; win = NL; waddr = 0;
    if (!rst) begin
      out_q.delete();
      acc_m = '0; coll_m = '0;
      hist = '{default: '0};
    end else begin
      for (int k = 0; k < NL; k++) begin
        int x, y, lx, ly, a;
        bit h;
        x = int'(curr_x_i); y = int'(curr_y_i);
        lx = int'(layer_x_i[k*CW +: CW]); ly = int'(layer_y_i[k*CW +: CW]);
        h = layer_en_i[k] && x >= lx && x < lx + 32 && y >= ly && y < ly + 32;
        a = h ? (x - lx) + (y - ly) * 32 : 0;
        c.addr[k*AW +: AW] = a[AW-1:0];
        op[k] = h && (mem[k][a] != 12'h000);
        if (op[k] && win == NL) begin win = k; waddr = a; end
      end
      if (pix_valid_i) begin
        o.layer = win;
        o.color = (win < NL) ? mem[win][waddr] : bg_color_i;
        out_q.push_back(o);
      end
      contrib = (pix_valid_i && $countones(op) >= 2) ? op : '0;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = contrib;
      if (frame_start_i) begin coll_m = acc_m | hist[2]; acc_m = '0; end
      else acc_m = acc_m | hist[2];
    end
`ifdef SPRITE_COMP_COLLIDE_EN
    c.coll = coll_m;
`else
    c.coll = '0;
`endif
    cyc_q.push_back(c);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    pix_valid_i = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic set_layer(int k, int x, int y);
    layer_x_i[k*CW +: CW] = CW'(x);
    layer_y_i[k*CW +: CW] = CW'(y);
  endtask

  task automatic pix(int x, int y);
    curr_x_i = CW'(x); curr_y_i = CW'(y);
    pix_valid_i = 1'b1;
    bg_color_i = 12'($urandom);
  endtask

  task automatic fill(int k, logic [11:0] v);
    for (int a = 0; a < 1024; a++) mem[k][a] = v;
  endtask

  task automatic fill_rand(int k);
    for (int a = 0; a < 1024; a++)
      mem[k][a] = ($urandom_range(3) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_valid"},   out_valid_o, 0);
    chk({tag, "_color"},   out_color_o, 0);
    chk({tag, "_layer"},   out_layer_o, NL);
    chk({tag, "_collide"}, collide_frame_o, 0);
    chk({tag, "_addr"},    rom_addr_o, 0);
  endtask

  // Monitor: per-cycle address/collision expectations, and one pixel popped per out_valid.
  always @(posedge clk) begin
    #1;
    if (cyc_q.size() > 0) begin
      cyc_t c;
      c = cyc_q.pop_front();
      chk("rom_addr", rom_addr_o, c.addr);
      chk("collide_frame", collide_frame_o, c.coll);
    end
    if (out_valid_o) begin
      if (out_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_out: got color %0h layer %0d expected no output", out_color_o, out_layer_o);
      end else begin
        out_t o;
        o = out_q.pop_front();
        chk("out_color", out_color_o, o.color);
        chk("out_layer", out_layer_o, o.layer);
      end
    end else begin
      chk("idle_color", out_color_o, 0);
      chk("idle_layer", out_layer_o, NL);
    end
  end

  initial begin
    for (int k = 0; k < NL; k++) fill_rand(k);
    rst = 1'b0;
    cycle(); cycle();
    chk_reset_state("reset");
    rst = 1'b1;

    // Single opaque layer, address and 3-cycle latency.
    fill(0, 12'hF00); set_layer(0, 100, 100); layer_en_i = 4'b0001;
    pix(110, 105); cycle();
    pix_valid_i = 1'b0;
    chk("p1_addr0", rom_addr_o[AW-1:0], 170);
    idle(4);

    // Two overlapping layers: transparent top, then opaque top with collision.
    fill(0, 12'h000); fill(1, 12'h0F0);
    set_layer(0, 50, 50); set_layer(1, 50, 50); layer_en_i = 4'b0011;
    for (int i = 0; i < 5; i++) begin pix(50 + $urandom_range(31), 50 + $urandom_range(31)); cycle(); end
    idle(4);
    fill(0, 12'h00F);
    for (int i = 0; i < 5; i++) begin pix(50 + $urandom_range(31), 50 + $urandom_range(31)); cycle(); end
    idle(4);
    frame_start_i = 1'b1; cycle(); frame_start_i = 1'b0; cycle();
`ifdef SPRITE_COMP_COLLIDE_EN
    chk("collide_overlap", collide_frame_o, 4'b0011);
`else
    chk("collide_overlap", collide_frame_o, 4'b0000);
`endif
    set_layer(1, 300, 300);
    for (int i = 0; i < 5; i++) begin pix(50 + $urandom_range(31), 50 + $urandom_range(31)); cycle(); end
    idle(4);
    frame_start_i = 1'b1; cycle(); frame_start_i = 1'b0; cycle();
    chk("collide_clear", collide_frame_o, 4'b0000);

    // Right edge of a sprite at the origin.
    fill_rand(2); mem[2][31] = 12'hABC;
    set_layer(2, 0, 0); layer_en_i = 4'b0100;
    pix(31, 0); cycle();
    chk("edge_addr31", rom_addr_o[2*AW +: AW], 31);
    pix(32, 0); cycle();
    idle(4);

    // Sprite near the coordinate maximum must not wrap.
    fill_rand(3); mem[3][7] = 12'h123;
    set_layer(3, 2040, 0); layer_en_i = 4'b1000;
    pix(5, 0); cycle();
    chk("nowrap_addr", rom_addr_o[3*AW +: AW], 0);
    pix(2047, 0); cycle();
    chk("wrap_edge_addr", rom_addr_o[3*AW +: AW], 7);
    idle(4);

    // Randomized traffic with overlaps, frame pulses and a mid-stream reset.
    for (int k = 0; k < NL; k++) fill_rand(k);
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) begin
        for (int k = 0; k < NL; k++) set_layer(k, $urandom_range(80), $urandom_range(80));
        layer_en_i = 4'($urandom);
      end
      pix($urandom_range(120), $urandom_range(120));
      pix_valid_i   = ($urandom_range(99) < 85);
      frame_start_i = ($urandom_range(99) < 3);
      if (i == 700) begin
        rst = 1'b0; cycle();
        chk_reset_state("midreset");
        rst = 1'b1;
        pix($urandom_range(120), $urandom_range(120)); cycle();
        chk("rel_valid1", out_valid_o, 0);
        pix($urandom_range(120), $urandom_range(120)); cycle();
        chk("rel_valid2", out_valid_o, 0);
      end else begin
        cycle();
      end
    end
    frame_start_i = 1'b0;
    idle(6);
    chk("drain_empty", out_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
